// File: rtl/slot_ctl_pkg.sv
// Shared definitions for the slot controller: slot FSM encodings, register
// offsets and CTRL/STATUS bit positions.
package slot_ctl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_KILL = 2'b01,
        ST_HOLD = 2'b10
    } slot_state_e;

    localparam logic [15:0] CTRL_OFS   = 16'd0;
    localparam logic [15:0] STATUS_OFS = 16'd1;
    localparam logic [15:0] KICK_OFS   = 16'd2;

    // CTRL: one bit per slot 1..3 in each field
    localparam int CTRL_KILL_LSB = 1;
    localparam int CTRL_HOLD_LSB = 5;
    localparam int CTRL_REL_LSB  = 9;
    localparam int CTRL_CLR_BIT  = 12;

    localparam int STAT_EXP_LSB  = 9;
    localparam int STAT_ILL_BIT  = 15;

endpackage

// File: rtl/slot_fsm.sv
// Per-slot kill/hold sequencer with optional watchdog (SLOT_CTL_WDOG_EN).
//   state | meaning
//   RUN   | slot executes normally
//   KILL  | kill request asserted, down-counter running
//   HOLD  | kill request held until released by slot 0
module slot_fsm
    import slot_ctl_pkg::*;
#(
    parameter int          KILL_CLKS  = 8,
    parameter logic [15:0] WDOG_LIMIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kill,
    input  logic        hold,
    input  logic        rel,
`ifdef SLOT_CTL_WDOG_EN
    input  logic        turn,
    input  logic        kick,
`endif
    output slot_state_e state,
    output logic        kill_rq,
    output logic        expire
);

    localparam int KCW = (KILL_CLKS > 2) ? $clog2(KILL_CLKS) : 1;
    localparam logic [KCW-1:0] KILL_LOAD = KCW'(KILL_CLKS - 1);

    slot_state_e    state_n;
    logic [KCW-1:0] cnt, cnt_n;
    logic           hold_q, hold_n;
    logic           wd_fire;
    logic           kill_any;

`ifdef SLOT_CTL_WDOG_EN
    logic [15:0] wd_cnt;

    assign wd_fire = turn && !kick && (state == ST_RUN) && (wd_cnt == WDOG_LIMIT - 16'd1);

    // Turn counter only accumulates while the slot is running
    always_ff @(posedge clk) begin
        if (reset)
            wd_cnt <= '0;
        else if (kick || wd_fire || state_n != ST_RUN)
            wd_cnt <= '0;
        else if (turn)
            wd_cnt <= wd_cnt + 16'd1;
    end
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_LIMIT == 16'd0);
    assign wd_fire = 1'b0;
`endif

    assign kill_any = kill || wd_fire;
    assign expire   = wd_fire;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hold_n  = hold_q;
        case (state)
            ST_RUN: begin
                if (kill_any) begin
                    state_n = ST_KILL;
                    cnt_n   = KILL_LOAD;
                    hold_n  = kill && hold;
                end
            end
            ST_KILL: begin
                if (kill) begin
                    cnt_n  = KILL_LOAD;
                    hold_n = hold;
                end else if (cnt == '0) begin
                    state_n = hold_q ? ST_HOLD : ST_RUN;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (kill) begin
                    state_n = ST_KILL;
                    cnt_n   = KILL_LOAD;
                    hold_n  = hold;
                end else if (rel) begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = ST_RUN;
                cnt_n   = '0;
                hold_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            cnt     <= '0;
            hold_q  <= 1'b0;
            kill_rq <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hold_q  <= hold_n;
            kill_rq <= (state_n != ST_RUN);
        end
    end

endmodule

// File: rtl/slot_ctl.sv
// Slot kill/hold controller: CTRL/STATUS/KICK register decode, sticky flags,
// three slot_fsm instances. Watchdog enabled by SLOT_CTL_WDOG_EN.
module slot_ctl
    import slot_ctl_pkg::*;
#(
    parameter logic [15:0] IO_BASE    = 16'h0040,
    parameter int          KILL_CLKS  = 8,
    parameter logic [15:0] WDOG_LIMIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [1:0]  io_slot,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] rd_data,
    output logic [3:0]  kill_slot_rq
);

    localparam logic [15:0] CTRL_ADDR   = IO_BASE + CTRL_OFS;
    localparam logic [15:0] STATUS_ADDR = IO_BASE + STATUS_OFS;

    logic        ctrl_hit, ctrl_ok, ill_set, clr;
    logic        ill_q;
    logic [3:1]  exp_q, exp_p, krq;
    logic [15:0] status;
    slot_state_e st [1:3];

    assign ctrl_hit = io_wr && (mem_addr == CTRL_ADDR);
    assign ctrl_ok  = ctrl_hit && (io_slot == 2'd0);
    assign ill_set  = ctrl_hit && (io_slot != 2'd0);
    assign clr      = ctrl_ok && dout[CTRL_CLR_BIT];

`ifdef SLOT_CTL_WDOG_EN
    localparam logic [15:0] KICK_ADDR = IO_BASE + KICK_OFS;
    logic kick_hit;
    assign kick_hit = io_wr && (mem_addr == KICK_ADDR);
`endif

    for (genvar g = 1; g <= 3; g++) begin : g_slot
        slot_fsm #(
            .KILL_CLKS  (KILL_CLKS),
            .WDOG_LIMIT (WDOG_LIMIT)
        ) u_fsm (
            .clk     (clk),
            .reset   (reset),
            .kill    (ctrl_ok && dout[CTRL_KILL_LSB + g - 1]),
            .hold    (dout[CTRL_HOLD_LSB + g - 1]),
            .rel     (ctrl_ok && dout[CTRL_REL_LSB + g - 1]),
`ifdef SLOT_CTL_WDOG_EN
            .turn    (io_slot == 2'(g)),
            .kick    (kick_hit && (io_slot == 2'(g))),
`endif
            .state   (st[g]),
            .kill_rq (krq[g]),
            .expire  (exp_p[g])
        );
    end

    // A new event on the same edge as a clear leaves its flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_q <= 1'b0;
            exp_q <= '0;
        end else begin
            ill_q <= ill_set | (ill_q & ~clr);
            exp_q <= exp_p | (exp_q & {3{~clr}});
        end
    end

    always_comb begin
        status = '0;
        for (int i = 1; i <= 3; i++)
            status[2*i +: 2] = st[i];
        status[STAT_EXP_LSB +: 3] = exp_q;
        status[STAT_ILL_BIT]      = ill_q;
    end

    assign rd_data      = (io_rd && (mem_addr == STATUS_ADDR)) ? status : 16'h0000;
    assign kill_slot_rq = {krq, 1'b0};

    logic unused_dout;
    assign unused_dout = &{1'b0, dout[0], dout[4], dout[8], dout[15:13]};

endmodule

// File: tb/tb_slot_ctl.sv
// Directed self-checking bench for slot_ctl (watchdog steps need SLOT_CTL_WDOG_EN).
module tb_slot_ctl;

    localparam logic [15:0] BASE   = 16'h0040;
    localparam logic [15:0] A_CTRL = BASE;
    localparam logic [15:0] A_STAT = BASE + 16'd1;
    localparam logic [15:0] A_KICK = BASE + 16'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic [1:0]  io_slot = 2'd0;
    logic [15:0] mem_addr = 16'h0;
    logic [15:0] dout = 16'h0;
    logic [15:0] rd_data;
    logic [3:0]  kill_slot_rq;

    int total = 0;
    int bad = 0;
    logic [15:0] sv;

    slot_ctl #(
        .IO_BASE    (BASE),
        .KILL_CLKS  (8),
        .WDOG_LIMIT (16'd16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_wr        (io_wr),
        .io_rd        (io_rd),
        .io_slot      (io_slot),
        .mem_addr     (mem_addr),
        .dout         (dout),
        .rd_data      (rd_data),
        .kill_slot_rq (kill_slot_rq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at a negedge; write is captured on the next posedge, returns at the following negedge
    task automatic wr(input logic [1:0] s, input logic [15:0] a, input logic [15:0] d);
        io_wr = 1'b1; io_slot = s; mem_addr = a; dout = d;
        @(negedge clk);
        io_wr = 1'b0; io_slot = 2'd0; mem_addr = 16'h0; dout = 16'h0;
    endtask

    task automatic rd_status(output logic [15:0] v);
        io_rd = 1'b1; mem_addr = A_STAT;
        #1;
        v = rd_data;
        io_rd = 1'b0; mem_addr = 16'h0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_krq", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("rst_status", sv, 16'h0000);
        io_rd = 1'b0; mem_addr = A_STAT; #1;
        chk("rd_no_strobe", rd_data, 16'h0000);
        mem_addr = 16'h0;

        // kill slot 1, 8-clock pulse
        wr(2'd0, A_CTRL, 16'h0002);
        chk("k1_first", {12'h0, kill_slot_rq}, 16'h0002);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk("k1_hold8", {12'h0, kill_slot_rq}, 16'h0002);
            if (k == 3) begin rd_status(sv); chk("k1_status", sv, 16'h0004); end
        end
        @(negedge clk);
        chk("k1_end", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("k1_status_run", sv, 16'h0000);

        // release in RUN ignored
        wr(2'd0, A_CTRL, 16'h0200);
        rd_status(sv); chk("rel_in_run", sv, 16'h0000);

        // kill+hold slot 3, then release
        wr(2'd0, A_CTRL, 16'h0088);
        chk("k3_first", {12'h0, kill_slot_rq}, 16'h0008);
        repeat (8) @(negedge clk);
        chk("k3_held", {12'h0, kill_slot_rq}, 16'h0008);
        rd_status(sv); chk("k3_status_hold", sv, 16'h0080);
        repeat (3) @(negedge clk);
        chk("k3_still_held", {12'h0, kill_slot_rq}, 16'h0008);
        wr(2'd0, A_CTRL, 16'h0800);
        chk("k3_released", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("k3_status_run", sv, 16'h0000);

        // illegal write from slot 2, then clear
        wr(2'd2, A_CTRL, 16'h000E);
        chk("ill_krq", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("ill_status", sv, 16'h8000);
        wr(2'd0, A_CTRL, 16'h1000);
        rd_status(sv); chk("ill_cleared", sv, 16'h0000);

        // address mismatch: no side effects
        wr(2'd0, BASE + 16'd3, 16'h000E);
        wr(2'd0, A_STAT, 16'h000E);
        wr(2'd0, BASE + 16'h0100, 16'h000E);
        chk("miss_krq", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("miss_status", sv, 16'h0000);

        // kill+release together acts as kill; reset on 4th kill clock
        wr(2'd0, A_CTRL, 16'h0202);
        chk("kr_kill", {12'h0, kill_slot_rq}, 16'h0002);
        rd_status(sv); chk("kr_status", sv, 16'h0004);
        @(negedge clk);
        @(negedge clk);
        chk("kr_3rd", {12'h0, kill_slot_rq}, 16'h0002);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("kr_rst_krq", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("kr_rst_status", sv, 16'h0000);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("kr_no_residual", {12'h0, kill_slot_rq}, 16'h0);

        // kill during KILL restarts the counter
        wr(2'd0, A_CTRL, 16'h0002);
        @(negedge clk);
        @(negedge clk);
        wr(2'd0, A_CTRL, 16'h0002);
        repeat (7) @(negedge clk);
        chk("restart_still", {12'h0, kill_slot_rq}, 16'h0002);
        @(negedge clk);
        chk("restart_end", {12'h0, kill_slot_rq}, 16'h0);

        // kill+hold slot 2, then kill (no hold) from HOLD -> KILL -> RUN
        wr(2'd0, A_CTRL, 16'h0044);
        repeat (8) @(negedge clk);
        rd_status(sv); chk("k2_hold", sv, 16'h0020);
        wr(2'd0, A_CTRL, 16'h0004);
        rd_status(sv); chk("k2_rekill", sv, 16'h0010);
        chk("k2_krq", {12'h0, kill_slot_rq}, 16'h0004);
        repeat (8) @(negedge clk);
        chk("k2_run_krq", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("k2_run_status", sv, 16'h0000);

`ifdef SLOT_CTL_WDOG_EN
        // slot 1 never kicks: expiry on the 16th turn
        io_slot = 2'd1;
        repeat (15) @(negedge clk);
        chk("wd_pre", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("wd_pre_status", sv, 16'h0000);
        @(negedge clk);
        io_slot = 2'd0;
        chk("wd_fire_krq", {12'h0, kill_slot_rq}, 16'h0002);
        rd_status(sv); chk("wd_fire_status", sv, 16'h0204);
        repeat (7) @(negedge clk);
        chk("wd_kill_last", {12'h0, kill_slot_rq}, 16'h0002);
        @(negedge clk);
        chk("wd_restart", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("wd_flag_sticky", sv, 16'h0200);
        wr(2'd0, A_CTRL, 16'h1000);
        rd_status(sv); chk("wd_flag_clr", sv, 16'h0000);

        // periodic kicks keep slot 1 alive
        for (int r = 0; r < 4; r++) begin
            io_slot = 2'd1;
            repeat (10) @(negedge clk);
            wr(2'd1, A_KICK, 16'h0000);
        end
        chk("wd_kicked_krq", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("wd_kicked_status", sv, 16'h0000);
`else
        // no watchdog: turns and KICK writes have no effect
        io_slot = 2'd1;
        repeat (20) @(negedge clk);
        io_slot = 2'd0;
        wr(2'd1, A_KICK, 16'hFFFF);
        chk("nowd_krq", {12'h0, kill_slot_rq}, 16'h0);
        rd_status(sv); chk("nowd_status", sv, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
